mul_sequencer: RTL

Multi-cycle shift-and-add controller that computes the 64-bit MUL result by sequencing the shared 64-bit ALU.
- The ALU stays outside this block. This block drives the ALU's A, B and cntrl inputs and consumes its result.
- Sits beside the EX stage. The pipeline issues a multiply through a start/ready/done handshake and stalls until done.
- Product is the low 64 bits, so it is correct for signed and unsigned operands alike.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 26 ++
 rtl/mul_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; time-shared between the EX stage and mul_sequencer.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (cntrl)
      ALU_PASS_B: result = b;
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier controller driving the external shared ALU, one iteration per cycle.
// Define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_t       state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] product_reg, product_next;
  logic             early_exit;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign early_exit = (mplier_reg == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      count_reg   <= count_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    count_next   = count_reg;
    product_next = product_reg;
    ready        = 1'b0;
    done         = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_cntrl    = ALU_PASS_B;

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          mcand_next  = a;
          mplier_next = b;
          acc_next    = '0;
          count_next  = '0;
          state_next  = CALC;
        end
      end

      CALC: begin
        if (early_exit) begin
          // Remaining partial products are all zero, so acc already holds the result.
          product_next = acc_reg;
          state_next   = DONE;
        end else begin
          alu_a = acc_reg;
          if (mplier_reg[0]) begin
            alu_cntrl = ALU_ADD;
            alu_b     = mcand_reg;
          end else begin
            // Pass acc through so the ALU path is identical every iteration.
            alu_cntrl = ALU_PASS_B;
            alu_b     = acc_reg;
          end
          acc_next    = alu_result;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg + 1'b1;
          if (count_reg == LAST_ITER) begin
            product_next = alu_result;
            state_next   = DONE;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign product = product_reg;

endmodule
